// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared encodings for the memory-access stage
//   funct3 load/store codes, FSM states, data-bus lane count, funct3 legality helper
package mem_stage_pkg;
  localparam int unsigned BUS_LANES = 4;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;
  function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
    return is_load ? (f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU})
                   : (f3 inside {F3_SB, F3_SH, F3_SW});
  endfunction
endpackage

// File: rtl/mem_load_ext.sv
// mem_load_ext: selects the addressed byte/half lane of a bus word and sign/zero extends it
//   off_i: addr[1:0], mode_i: load funct3, rdata_i: raw bus word, val_o: extended result
module mem_load_ext
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      off_i,
  input  logic [2:0]      mode_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] val_o
);
  logic [XLEN-1:0] lane;
  logic            sx;
  assign lane = rdata_i >> {off_i, 3'b000};
  assign sx   = ~mode_i[2];
  always_comb
    val_o = (mode_i == F3_LW) ? rdata_i :
            (mode_i inside {F3_LH, F3_LHU}) ? {{(XLEN-16){sx & lane[15]}}, lane[15:0]} :
            {{(XLEN-8){sx & lane[7]}}, lane[7:0]};
endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage; drives the req/gnt/rvalid data bus and registers writeback
//   in : alu_val/rd/rd_we/rs2/mem_re/mem_we/mode from EXE/MEM, dmem_gnt/rvalid/rdata from bus
//   out: dmem_req/we/addr/be/wdata to bus, wb_val/rd_addr/rd_we/misalign to WB, stall upstream
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [XLEN-1:0]      alu_val_i,
  input  logic [RADDR-1:0]     rd_addr_i,
  input  logic                 rd_we_i,
  input  logic [XLEN-1:0]      rs2_val_i,
  input  logic                 mem_re_i,
  input  logic                 mem_we_i,
  input  logic [2:0]           mem_mode_i,
  output logic                 dmem_req_o,
  output logic                 dmem_we_o,
  output logic [XLEN-1:0]      dmem_addr_o,
  output logic [BUS_LANES-1:0] dmem_be_o,
  output logic [XLEN-1:0]      dmem_wdata_o,
  input  logic                 dmem_gnt_i,
  input  logic                 dmem_rvalid_i,
  input  logic [XLEN-1:0]      dmem_rdata_i,
  output logic [XLEN-1:0]      wb_val_o,
  output logic [RADDR-1:0]     rd_addr_o,
  output logic                 rd_we_o,
  output logic                 misalign_o,
  output logic                 stall_o
);
  state_e               state_q, state_d;
  logic                 req_q, req_d, we_q, we_d;
  logic [XLEN-1:0]      addr_q, addr_d, wdata_q, wdata_d, wb_q, wb_d;
  logic [BUS_LANES-1:0] be_q, be_d;
  logic [RADDR-1:0]     rd_q, rd_d, lrd_q, lrd_d;
  logic                 rd_we_q, rd_we_d, lrd_we_q, lrd_we_d, mis_q, mis_d;
  logic [2:0]           mode_q, mode_d;
  logic [1:0]           off_q, off_d;
  logic                 access, bad, is_half, is_word;
  logic [BUS_LANES-1:0] be_n;
  logic [XLEN-1:0]      wdata_n, ext_val;
  assign access  = mem_re_i ^ mem_we_i;
  assign is_half = mem_mode_i[1:0] == 2'b01;
  assign is_word = mem_mode_i[1:0] == 2'b10;
  // both strobes high, unknown funct3, or a misaligned half/word all take the error path
  assign bad = (mem_re_i & mem_we_i) |
               (access & (~f3_legal(mem_re_i, mem_mode_i) | (is_half & alu_val_i[0]) |
                          (is_word & |alu_val_i[1:0])));
  assign be_n = is_word ? 4'b1111 : ((is_half ? 4'b0011 : 4'b0001) << alu_val_i[1:0]);
  // replication puts the data in every lane, so the lane picked by be_n is always correct
  assign wdata_n = is_word ? rs2_val_i :
                   is_half ? {(XLEN/16){rs2_val_i[15:0]}} : {(XLEN/8){rs2_val_i[7:0]}};
  assign stall_o = (state_q == S_IDLE) ? (access & ~bad) :
                   (state_q == S_REQ)  ? ~(dmem_gnt_i & we_q) :
                   (state_q == S_WAIT) ? ~dmem_rvalid_i : 1'b0;
  mem_load_ext #(.XLEN(XLEN)) u_ext (
    .off_i  (off_q),
    .mode_i (mode_q),
    .rdata_i(dmem_rdata_i),
    .val_o  (ext_val)
  );
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    lrd_d    = lrd_q;
    lrd_we_d = lrd_we_q;
    mode_d   = mode_q;
    off_d    = off_q;
    wb_d     = wb_q;
    rd_d     = rd_q;
    rd_we_d  = 1'b0;
    mis_d    = 1'b0;
    case (state_q)
      S_IDLE:
        if (bad) mis_d = 1'b1;
        else if (access) begin
          state_d  = S_REQ;
          req_d    = 1'b1;
          we_d     = mem_we_i;
          addr_d   = {alu_val_i[XLEN-1:2], 2'b00};
          be_d     = be_n;
          wdata_d  = wdata_n;
          lrd_d    = rd_addr_i;
          lrd_we_d = rd_we_i;
          mode_d   = mem_mode_i;
          off_d    = alu_val_i[1:0];
        end else begin
          wb_d    = alu_val_i;
          rd_d    = rd_addr_i;
          rd_we_d = rd_we_i;
        end
      S_REQ:
        if (dmem_gnt_i) begin
          req_d   = 1'b0;
          state_d = we_q ? S_IDLE : S_WAIT;
        end
      S_WAIT:
        if (dmem_rvalid_i) begin
          wb_d    = ext_val;
          rd_d    = lrd_q;
          rd_we_d = lrd_we_q;
          state_d = S_IDLE;
        end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i)
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      lrd_q    <= '0;
      lrd_we_q <= 1'b0;
      mode_q   <= '0;
      off_q    <= '0;
      wb_q     <= '0;
      rd_q     <= '0;
      rd_we_q  <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      lrd_q    <= lrd_d;
      lrd_we_q <= lrd_we_d;
      mode_q   <= mode_d;
      off_q    <= off_d;
      wb_q     <= wb_d;
      rd_q     <= rd_d;
      rd_we_q  <= rd_we_d;
      mis_q    <= mis_d;
    end
  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;
  assign wb_val_o     = wb_q;
  assign rd_addr_o    = rd_q;
  assign rd_we_o      = rd_we_q;
  assign misalign_o   = mis_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed-vector bench for mem_stage
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] alu_val, rs2_val, dmem_addr, dmem_wdata, dmem_rdata, wb_val;
  logic [4:0]  rd_addr, rd_addr_o;
  logic        rd_we, mem_re, mem_we, dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic        rd_we_o, misalign, stall;
  logic [2:0]  mem_mode;
  logic [3:0]  dmem_be;
  int          n_vec = 0;
  int          n_err = 0;
  always #5 clk = ~clk;
  mem_stage dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .alu_val_i    (alu_val),
    .rd_addr_i    (rd_addr),
    .rd_we_i      (rd_we),
    .rs2_val_i    (rs2_val),
    .mem_re_i     (mem_re),
    .mem_we_i     (mem_we),
    .mem_mode_i   (mem_mode),
    .dmem_req_o   (dmem_req),
    .dmem_we_o    (dmem_we),
    .dmem_addr_o  (dmem_addr),
    .dmem_be_o    (dmem_be),
    .dmem_wdata_o (dmem_wdata),
    .dmem_gnt_i   (dmem_gnt),
    .dmem_rvalid_i(dmem_rvalid),
    .dmem_rdata_i (dmem_rdata),
    .wb_val_o     (wb_val),
    .rd_addr_o    (rd_addr_o),
    .rd_we_o      (rd_we_o),
    .misalign_o   (misalign),
    .stall_o      (stall)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic clr;
    alu_val = 0; rs2_val = 0; rd_addr = 0; rd_we = 0;
    mem_re = 0; mem_we = 0; mem_mode = 0;
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
  endtask
  task automatic drive(input logic [31:0] a, input logic re, input logic we,
                       input logic [2:0] md, input logic [4:0] rd, input logic rdwe);
    alu_val = a; mem_re = re; mem_we = we; mem_mode = md; rd_addr = rd; rd_we = rdwe;
  endtask
  initial begin
    clr();
    rst_n = 0;
    cyc(); cyc();
    check("rst_req", {31'd0, dmem_req}, 0);
    check("rst_we", {31'd0, dmem_we}, 0);
    check("rst_addr", dmem_addr, 0);
    check("rst_be", {28'd0, dmem_be}, 0);
    check("rst_wdata", dmem_wdata, 0);
    check("rst_wb", wb_val, 0);
    check("rst_rd", {27'd0, rd_addr_o}, 0);
    check("rst_rdwe", {31'd0, rd_we_o}, 0);
    check("rst_mis", {31'd0, misalign}, 0);
    rst_n = 1;
    // plain ALU pass-through
    drive(32'h1234, 0, 0, 3'b000, 5, 1);
    #1 check("alu_stall", {31'd0, stall}, 0);
    cyc();
    check("alu_wb", wb_val, 32'h1234);
    check("alu_rd", {27'd0, rd_addr_o}, 5);
    check("alu_rdwe", {31'd0, rd_we_o}, 1);
    clr();
    // LB at 0x103, immediate grant, rvalid one cycle later
    drive(32'h103, 1, 0, 3'b000, 7, 1);
    dmem_gnt = 1;
    #1 check("lb_stall0", {31'd0, stall}, 1);
    cyc();
    check("lb_req", {31'd0, dmem_req}, 1);
    check("lb_addr", dmem_addr, 32'h100);
    check("lb_be", {28'd0, dmem_be}, 32'h8);
    check("lb_we", {31'd0, dmem_we}, 0);
    check("lb_rdwe_req", {31'd0, rd_we_o}, 0);
    check("lb_stall1", {31'd0, stall}, 1);
    cyc();
    check("lb_req_wait", {31'd0, dmem_req}, 0);
    check("lb_rdwe_wait", {31'd0, rd_we_o}, 0);
    dmem_gnt = 0; dmem_rvalid = 1; dmem_rdata = 32'h80FF_FF00;
    #1 check("lb_stall2", {31'd0, stall}, 0);
    cyc();
    check("lb_wb", wb_val, 32'hFFFF_FF80);
    check("lb_rd", {27'd0, rd_addr_o}, 7);
    check("lb_rdwe", {31'd0, rd_we_o}, 1);
    clr();
    cyc();
    check("lb_rdwe_once", {31'd0, rd_we_o}, 0);
    // LHU at 0x102
    drive(32'h102, 1, 0, 3'b101, 9, 1);
    dmem_gnt = 1;
    cyc();
    check("lhu_be", {28'd0, dmem_be}, 32'hC);
    check("lhu_addr", dmem_addr, 32'h100);
    cyc();
    dmem_gnt = 0; dmem_rvalid = 1; dmem_rdata = 32'hBEEF_0000;
    cyc();
    check("lhu_wb", wb_val, 32'h0000_BEEF);
    check("lhu_rdwe", {31'd0, rd_we_o}, 1);
    clr();
    cyc();
    // SB at 0x201 with grant delayed three cycles
    drive(32'h201, 0, 1, 3'b000, 0, 0);
    rs2_val = 32'hAB;
    cyc();
    check("sb_we", {31'd0, dmem_we}, 1);
    check("sb_be", {28'd0, dmem_be}, 32'h2);
    check("sb_lane1", (dmem_wdata >> 8) & 32'hFF, 32'hAB);
    for (int i = 0; i < 3; i++) begin
      check("sb_req_hold", {31'd0, dmem_req}, 1);
      check("sb_addr_hold", dmem_addr, 32'h200);
      check("sb_stall_hold", {31'd0, stall}, 1);
      check("sb_rdwe_hold", {31'd0, rd_we_o}, 0);
      cyc();
    end
    dmem_gnt = 1;
    #1 check("sb_stall_gnt", {31'd0, stall}, 0);
    check("sb_req_gnt", {31'd0, dmem_req}, 1);
    cyc();
    check("sb_req_done", {31'd0, dmem_req}, 0);
    check("sb_rdwe_done", {31'd0, rd_we_o}, 0);
    clr();
    // SH at 0x402 puts the halfword in the upper lanes
    drive(32'h402, 0, 1, 3'b001, 0, 0);
    rs2_val = 32'h1234_5678;
    cyc();
    check("sh_be", {28'd0, dmem_be}, 32'hC);
    check("sh_hi", dmem_wdata >> 16, 32'h5678);
    dmem_gnt = 1;
    cyc();
    clr();
    // misaligned LW
    drive(32'h102, 1, 0, 3'b010, 4, 1);
    #1 check("mis_stall", {31'd0, stall}, 0);
    cyc();
    check("mis_pulse", {31'd0, misalign}, 1);
    check("mis_req", {31'd0, dmem_req}, 0);
    check("mis_rdwe", {31'd0, rd_we_o}, 0);
    clr();
    cyc();
    check("mis_clear", {31'd0, misalign}, 0);
    // load and store strobes together
    drive(32'h100, 1, 1, 3'b000, 4, 1);
    #1 check("both_stall", {31'd0, stall}, 0);
    cyc();
    check("both_pulse", {31'd0, misalign}, 1);
    check("both_req", {31'd0, dmem_req}, 0);
    check("both_rdwe", {31'd0, rd_we_o}, 0);
    clr();
    // unknown load funct3
    drive(32'h100, 1, 0, 3'b011, 4, 1);
    cyc();
    check("badf3_pulse", {31'd0, misalign}, 1);
    check("badf3_req", {31'd0, dmem_req}, 0);
    clr();
    cyc();
    // reset while waiting for read data, then a stray rvalid
    drive(32'h300, 1, 0, 3'b010, 3, 1);
    dmem_gnt = 1;
    cyc();
    check("lw_be", {28'd0, dmem_be}, 32'hF);
    check("lw_addr", dmem_addr, 32'h300);
    cyc();
    dmem_gnt = 0;
    rst_n = 0;
    cyc();
    check("mrst_req", {31'd0, dmem_req}, 0);
    check("mrst_addr", dmem_addr, 0);
    check("mrst_be", {28'd0, dmem_be}, 0);
    check("mrst_rdwe", {31'd0, rd_we_o}, 0);
    rst_n = 1;
    clr();
    alu_val = 32'h55;
    dmem_rvalid = 1; dmem_rdata = 32'hDEAD_BEEF;
    #1 check("late_stall", {31'd0, stall}, 0);
    cyc();
    check("late_wb", wb_val, 32'h55);
    check("late_rdwe", {31'd0, rd_we_o}, 0);
    check("late_req", {31'd0, dmem_req}, 0);
    clr();
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
